// File: rtl/demux_1_8_ctrl_v.sv
// 1:8 burst demux controller: round-robin grant, BURST_LEN beats per grant.
// Ports: i_clk, i_n_rst (sync, active-low), i_en_mask, i_a/i_a_vld/o_a_rdy
// (source), o_sel_code, o_data, o_dst_vld/i_dst_rdy (destinations), o_busy,
// o_timeout. Optional stall timeout: define DEMUX_CTRL_TIMEOUT_EN.
module demux_1_8_ctrl_v #(
  parameter int WIDTH     = 1,
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic             i_clk,
  input  logic             i_n_rst,
  input  logic [7:0]       i_en_mask,
  input  logic [WIDTH-1:0] i_a,
  input  logic             i_a_vld,
  output logic             o_a_rdy,
  output logic [2:0]       o_sel_code,
  output logic [WIDTH-1:0] o_data,
  output logic [7:0]       o_dst_vld,
  input  logic [7:0]       i_dst_rdy,
  output logic             o_busy,
  output logic             o_timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    XFER = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] sel_q, sel_nxt;
  logic [4:0] beat_q, beat_nxt;

  logic [2:0] pick;
  logic       pick_vld;
  logic       sel_en;
  logic       sel_rdy;
  logic       fire;
  logic       last_beat;
  logic       stall;
  logic       tmo;

  // Rotating search starting one past the last grant; offset 8 wraps
  // back onto the current channel so a lone channel is re-selected.
  always_comb begin
    pick     = sel_q;
    pick_vld = 1'b0;
    for (int i = 8; i >= 1; i--) begin
      if (i_en_mask[sel_q + 3'(i)]) begin
        pick     = sel_q + 3'(i);
        pick_vld = 1'b1;
      end
    end
  end

  assign sel_en    = i_en_mask[sel_q];
  assign sel_rdy   = i_dst_rdy[sel_q];
  // Reset low kills any beat in the same cycle.
  assign fire      = i_n_rst && (state == XFER) && sel_en
                     && i_a_vld && sel_rdy;
  assign stall     = (state == XFER) && sel_en && i_a_vld && !sel_rdy;
  assign last_beat = (beat_q == 5'(BURST_LEN - 1));

`ifdef DEMUX_CTRL_TIMEOUT_EN
  logic [7:0] stall_q, stall_nxt;

  // stall_q counts earlier consecutive stalls, so this cycle is stall
  // number stall_q+1.
  assign tmo       = stall && (stall_q == 8'(TIMEOUT - 1));
  assign stall_nxt = stall ? stall_q + 8'd1 : 8'd0;

  always_ff @(posedge i_clk) begin
    if (!i_n_rst) begin
      stall_q <= 8'd0;
    end else begin
      stall_q <= stall_nxt;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_n_rst) begin
      state  <= IDLE;
      sel_q  <= 3'd7;
      beat_q <= 5'd0;
    end else begin
      state  <= state_nxt;
      sel_q  <= sel_nxt;
      beat_q <= beat_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_q;
    beat_nxt  = beat_q;
    unique case (state)
      IDLE: begin
        if (i_a_vld && (i_en_mask != 8'd0)) state_nxt = ARB;
      end
      ARB: begin
        if (pick_vld) begin
          sel_nxt   = pick;
          beat_nxt  = 5'd0;
          state_nxt = XFER;
        end else begin
          state_nxt = IDLE;
        end
      end
      XFER: begin
        if (!sel_en) begin
          state_nxt = ARB;
        end else if (fire) begin
          beat_nxt = beat_q + 5'd1;
          if (last_beat) state_nxt = ARB;
        end else if (tmo) begin
          state_nxt = ARB;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_dst_vld = 8'd0;
    o_a_rdy   = 1'b0;
    o_busy    = 1'b0;
    o_timeout = 1'b0;
    if (i_n_rst) begin
      unique case (state)
        IDLE: ;
        ARB:  o_busy = 1'b1;
        XFER: begin
          o_busy    = 1'b1;
          o_timeout = tmo;
          if (sel_en) begin
            o_dst_vld[sel_q] = i_a_vld;
            o_a_rdy          = sel_rdy;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_sel_code = sel_q;
  assign o_data     = i_a;

endmodule

// File: tb/tb_demux_1_8_ctrl_v.sv
// Directed table-driven bench for demux_1_8_ctrl_v.
// Each record: inputs for one cycle and the expected outputs before the edge.
module tb_demux_1_8_ctrl_v;

  logic       clk;
  logic       rst_n;
  logic [7:0] en_mask;
  logic [0:0] a;
  logic       a_vld;
  logic       a_rdy;
  logic [2:0] sel_code;
  logic [0:0] data;
  logic [7:0] dst_vld;
  logic [7:0] dst_rdy;
  logic       busy;
  logic       timeout;

  demux_1_8_ctrl_v dut (
    .i_clk      (clk),
    .i_n_rst    (rst_n),
    .i_en_mask  (en_mask),
    .i_a        (a),
    .i_a_vld    (a_vld),
    .o_a_rdy    (a_rdy),
    .o_sel_code (sel_code),
    .o_data     (data),
    .o_dst_vld  (dst_vld),
    .i_dst_rdy  (dst_rdy),
    .o_busy     (busy),
    .o_timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] mask;
    logic       vld;
    logic [7:0] rdy;
    logic [2:0] sel;
    logic [7:0] dvld;
    logic       ardy;
    logic       busy;
    logic       to;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;
  int   beats[8];

  task automatic add(input logic r, input logic [7:0] m, input logic v,
                     input logic [7:0] rd, input logic [2:0] s,
                     input logic [7:0] dv, input logic ar,
                     input logic b, input logic t);
    tbl.push_back('{r, m, v, rd, s, dv, ar, b, t});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    a_vld   = 1'b0;
    en_mask = 8'd0;
    dst_rdy = 8'd0;
    @(negedge clk);
  endtask

  task automatic run_table(input string tag);
    logic [23:0] got, exp;
    logic [0:0]  a_drv;
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      a_drv   = 1'($urandom);
      rst_n   = tbl[i].rst;
      en_mask = tbl[i].mask;
      a_vld   = tbl[i].vld;
      dst_rdy = tbl[i].rdy;
      a       = a_drv;
      #1;
      got = {sel_code, dst_vld, a_rdy, busy, timeout, data, 8'd0};
      exp = {tbl[i].sel, tbl[i].dvld, tbl[i].ardy, tbl[i].busy,
             tbl[i].to, a_drv, 8'd0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s step %0d: got sel=%0d dvld=%h rdy=%b busy=%b to=%b d=%b, want sel=%0d dvld=%h rdy=%b busy=%b to=%b d=%b",
                 tag, i, sel_code, dst_vld, a_rdy, busy, timeout, data,
                 tbl[i].sel, tbl[i].dvld, tbl[i].ardy, tbl[i].busy,
                 tbl[i].to, a_drv);
      end
      for (int c = 0; c < 8; c++)
        if (dst_vld[c] && dst_rdy[c]) beats[c]++;
    end
    tbl.delete();
  endtask

  task automatic chk_beats(input string tag, input int ch, input int want);
    checks++;
    if (beats[ch] != want) begin
      errors++;
      $display("FAIL %s ch%0d beats: got %0d want %0d",
               tag, ch, beats[ch], want);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    en_mask = 8'd0;
    a       = 1'b0;
    a_vld   = 1'b0;
    dst_rdy = 8'd0;

    // Full rotation 0..7 then back to 0.
    do_reset();
    foreach (beats[c]) beats[c] = 0;
    add(1, 8'hFF, 1, 8'hFF, 3'd7, 8'h00, 0, 0, 0);
    add(1, 8'hFF, 1, 8'hFF, 3'd7, 8'h00, 0, 1, 0);
    for (int ch = 0; ch < 8; ch++) begin
      for (int b = 0; b < 4; b++)
        add(1, 8'hFF, 1, 8'hFF, 3'(ch), 8'(1 << ch), 1, 1, 0);
      add(1, 8'hFF, 1, 8'hFF, 3'(ch), 8'h00, 0, 1, 0);
    end
    for (int b = 0; b < 4; b++)
      add(1, 8'hFF, 1, 8'hFF, 3'd0, 8'h01, 1, 1, 0);
    run_table("rotate");
    chk_beats("rotate", 0, 8);
    for (int c = 1; c < 8; c++) chk_beats("rotate", c, 4);

    // Sparse mask: 2,7,2,7.
    do_reset();
    add(1, 8'h84, 1, 8'hFF, 3'd7, 8'h00, 0, 0, 0);
    add(1, 8'h84, 1, 8'hFF, 3'd7, 8'h00, 0, 1, 0);
    for (int g = 0; g < 4; g++) begin
      for (int b = 0; b < 4; b++)
        add(1, 8'h84, 1, 8'hFF, g[0] ? 3'd7 : 3'd2,
            g[0] ? 8'h80 : 8'h04, 1, 1, 0);
      add(1, 8'h84, 1, 8'hFF, g[0] ? 3'd7 : 3'd2, 8'h00, 0, 1, 0);
    end
    run_table("sparse");

    // Single channel, valid toggling: grant held through gaps, re-picked.
    do_reset();
    add(1, 8'h08, 1, 8'hFF, 3'd7, 8'h00, 0, 0, 0);
    add(1, 8'h08, 1, 8'hFF, 3'd7, 8'h00, 0, 1, 0);
    for (int j = 0; j < 8; j++)
      add(1, 8'h08, j[0], 8'hFF, 3'd3, j[0] ? 8'h08 : 8'h00, 1, 1, 0);
    add(1, 8'h08, 1, 8'hFF, 3'd3, 8'h00, 0, 1, 0);
    add(1, 8'h08, 1, 8'hFF, 3'd3, 8'h08, 1, 1, 0);
    run_table("toggle");

    // Selected channel disabled mid-burst.
    do_reset();
    add(1, 8'h06, 1, 8'hFF, 3'd7, 8'h00, 0, 0, 0);
    add(1, 8'h06, 1, 8'hFF, 3'd7, 8'h00, 0, 1, 0);
    add(1, 8'h06, 1, 8'hFF, 3'd1, 8'h02, 1, 1, 0);
    add(1, 8'h06, 1, 8'hFF, 3'd1, 8'h02, 1, 1, 0);
    add(1, 8'h04, 1, 8'hFF, 3'd1, 8'h00, 0, 1, 0);
    add(1, 8'h04, 1, 8'hFF, 3'd1, 8'h00, 0, 1, 0);
    add(1, 8'h04, 1, 8'hFF, 3'd2, 8'h04, 1, 1, 0);
    run_table("disable");

    // Stalled channel 0.
    do_reset();
    add(1, 8'hFF, 1, 8'hFE, 3'd7, 8'h00, 0, 0, 0);
    add(1, 8'hFF, 1, 8'hFE, 3'd7, 8'h00, 0, 1, 0);
`ifdef DEMUX_CTRL_TIMEOUT_EN
    for (int k = 1; k <= 15; k++)
      add(1, 8'hFF, 1, 8'hFE, 3'd0, 8'h01, 0, 1, k == 15);
    add(1, 8'hFF, 1, 8'hFE, 3'd0, 8'h00, 0, 1, 0);
    add(1, 8'hFF, 1, 8'hFE, 3'd1, 8'h02, 1, 1, 0);
`else
    for (int k = 1; k <= 20; k++)
      add(1, 8'hFF, 1, 8'hFE, 3'd0, 8'h01, 0, 1, 0);
`endif
    run_table("stall");

    // Reset during beat 3 on channel 5.
    do_reset();
    foreach (beats[c]) beats[c] = 0;
    add(1, 8'h20, 1, 8'hFF, 3'd7, 8'h00, 0, 0, 0);
    add(1, 8'h20, 1, 8'hFF, 3'd7, 8'h00, 0, 1, 0);
    add(1, 8'h20, 1, 8'hFF, 3'd5, 8'h20, 1, 1, 0);
    add(1, 8'h20, 1, 8'hFF, 3'd5, 8'h20, 1, 1, 0);
    add(0, 8'h20, 1, 8'hFF, 3'd5, 8'h00, 0, 0, 0);
    add(1, 8'hFF, 1, 8'hFF, 3'd7, 8'h00, 0, 0, 0);
    add(1, 8'hFF, 1, 8'hFF, 3'd7, 8'h00, 0, 1, 0);
    add(1, 8'hFF, 1, 8'hFF, 3'd0, 8'h01, 1, 1, 0);
    run_table("midrst");
    chk_beats("midrst", 5, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
